// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with a small byte FIFO and sticky status.
//
// Ports
//   clk      : system clock, all state changes on its rising edge
//   reset_n  : asynchronous active-low reset
//   ps2_clk  : raw keyboard clock (asynchronous to clk)
//   ps2_data : raw keyboard data (asynchronous to clk)
//   ren      : read strobe; pops the head entry and clears sticky flags
//   data     : {nonempty, overflow, frame_err, 5'b0, head_byte}
//
// A frame is start(0), 8 data bits LSB first, odd parity, stop(1), each bit
// sampled on a falling edge of the synchronized keyboard clock. A completed
// frame is registered once (byte + verdict) and written into the FIFO on the
// following cycle, so a frame ending and a read strobe can meet in the same
// FIFO cycle without special casing.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       fall, bit_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  // ---------------------------------------------------------------- frame FSM
  state_t        state, state_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic          par_bit, par_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          push_nx, err_nx;
  logic          timeout;

  // A partial frame dies after TIMEOUT_CYCLES cycles with no falling edge.
  assign timeout = (state != S_IDLE) && !fall &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    par_nx     = par_bit;
    tmo_nx     = tmo_cnt;
    push_nx    = 1'b0;
    err_nx     = 1'b0;

    if (state == S_IDLE || fall) tmo_nx = '0;
    else                         tmo_nx = tmo_cnt + TW'(1);

    if (timeout) begin
      state_nx   = S_IDLE;
      shreg_nx   = '0;
      bit_cnt_nx = '0;
      tmo_nx     = '0;
      err_nx     = 1'b1;
    end else if (fall) begin
      unique case (state)
        S_IDLE: begin
          // A high sample here is line noise, not a start bit.
          if (!bit_in) begin
            state_nx   = S_DATA;
            bit_cnt_nx = '0;
          end
        end
        S_DATA: begin
          shreg_nx   = {bit_in, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = S_PARITY;
        end
        S_PARITY: begin
          par_nx   = bit_in;
          state_nx = S_STOP;
        end
        S_STOP: begin
          state_nx = S_IDLE;
          if (bit_in && (^{shreg, par_bit})) push_nx = 1'b1;
          else                               err_nx  = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  logic       push_q, err_q;
  logic [7:0] push_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      push_q    <= 1'b0;
      err_q     <= 1'b0;
      push_byte <= '0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      bit_cnt   <= bit_cnt_nx;
      par_bit   <= par_nx;
      tmo_cnt   <= tmo_nx;
      push_q    <= push_nx;
      err_q     <= err_nx;
      if (push_nx) push_byte <= shreg;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, wr, ovf_set;
  logic        overflow, frame_err;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = ren & ~empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr      = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      // A read clears the sticky flags, but a fresh event in the same cycle wins.
      overflow  <= (overflow  & ~ren) | ovf_set;
      frame_err <= (frame_err & ~ren) | err_q;
    end
  end

  assign data = {~empty, overflow, frame_err, 5'b0,
                 empty ? 8'h00 : mem[rptr[AW-1:0]]};

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: byte-queue model of the receiver, compared
// against data every cycle the model is settled, plus literal scenario checks.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ren = 1'b0;
  logic [15:0] data;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ren(ren), .data(data)
  );

  int checks = 0;
  int errors = 0;

  // Model: byte queue plus two sticky flags.
  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_ferr = 1'b0;
  bit mvalid = 1'b0;

  function automatic logic [15:0] model_data();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    return {(q.size() != 0), m_ovf, m_ferr, 5'b0, head};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (mvalid) chk("model", data, model_data());
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic m_frame(input logic [7:0] b, input bit good, input bit popped);
    if (popped) begin
      m_ovf = 1'b0;
      m_ferr = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
    end
    if (good) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(b);
    end else m_ferr = 1'b1;
  endtask

  // One PS/2 bit: set data while clock high, then a low pulse.
  task automatic drive_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    ps2_clk = 1'b0;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // ren_sync: strobe ren in the cycle the byte is written into the FIFO.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit ren_sync, input bit chk_lat);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
    @(negedge clk) ps2_data = bits[10];
    repeat ($urandom_range(3, 6)) @(negedge clk);
    mvalid = 1'b0;
    ps2_clk = 1'b0;
    if (chk_lat) begin
      repeat (3) @(posedge clk);
      #1 chk("lat_before", data, 16'h0000);
      @(posedge clk);
      #1 chk("lat_after", data, 16'h801C);
    end else if (ren_sync) begin
      repeat (3) @(posedge clk);
      @(negedge clk) ren = 1'b1;
      @(negedge clk) ren = 1'b0;
    end
    repeat ($urandom_range(3, 6)) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (6) @(negedge clk);
    ps2_data = 1'b1;
    m_frame(b, !bad_par && !bad_stop, ren_sync);
    mvalid = 1'b1;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
  endtask

  task automatic partial(input int n);
    mvalid = 1'b0;
    send_bits(n);
    repeat (TMO + 20) @(negedge clk);
    m_ferr = 1'b1;
    mvalid = 1'b1;
  endtask

  task automatic ren_pulse();
    @(negedge clk);
    mvalid = 1'b0;
    ren = 1'b1;
    @(negedge clk) ren = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    mvalid = 1'b1;
  endtask

  task automatic noise_edge();
    @(negedge clk) ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ren = 1'b0;
    mvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pulse_data", data, 16'h0000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_data", data, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    mvalid = 1'b1;
    chk("post_reset_data", data, 16'h0000);

    // Single good frame, exact latency.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s28_data", data, 16'h801C);
    ren_pulse();
    chk("s28_pop", data, 16'h0000);

    // Parity failure.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s29_ferr", data, 16'h2000);
    ren_pulse();
    chk("s29_clear", data, 16'h0000);

    // Overflow on the 9th byte, then drain.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s30_full", data, 16'hC001);
    for (int i = 1; i <= 8; i++) begin
      chk("s30_head", data, (i == 1) ? 16'hC001 : (16'h8000 | 16'(i)));
      ren_pulse();
    end
    chk("s30_empty", data, 16'h0000);

    // Timeout of a partial frame, then a good frame.
    partial(4);
    chk("s31_timeout", data, 16'h2000);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s31_next", data, 16'hA0F0);
    ren_pulse();
    chk("s31_clear", data, 16'h0000);

    // Full FIFO with ren landing on the push cycle.
    for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA9, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s32_ovf", {15'b0, data[14]}, 16'h0000);
    for (int i = 0; i < 7; i++) ren_pulse();
    chk("s32_last", data, 16'h80A9);
    ren_pulse();
    chk("s32_empty", data, 16'h0000);

    // New error in the same cycle as a clearing read keeps frame_err set.
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s21_ferr_hold", data, 16'h2000);
    ren_pulse();

    // Reset in mid-frame.
    mvalid = 1'b0;
    send_bits(5);
    pulse_reset();
    chk("s33_reset", data, 16'h0000);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s33_next", data, 16'h805A);

    // Randomized traffic.
    for (int n = 0; n < 50; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0,
                               1'($urandom_range(0, 1)), 1'b0);
        4: send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        5: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
        6, 7: ren_pulse();
        8: partial($urandom_range(1, 10));
        default: noise_edge();
      endcase
    end

    mvalid = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered bytes (power of two, ≥2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port ren  input  1  memory-side read strobe; pops head entry, clears sticky flags.
REQ-008 SHALL have port data  output  16  {nonempty, overflow, frame_err, 5'b0, head_byte}.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-010 SHALL detect a falling edge when synchronized ps2_clk is 1 in the previous cycle and 0 in the current cycle; one sample per edge.
REQ-011 SHALL implement states IDLE, DATA, PARITY, STOP; a frame is start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-012 SHALL, in IDLE, move to DATA on an edge with sampled data 0; an edge with data 1 leaves it in IDLE without error.
REQ-013 SHALL, in DATA, shift in one bit per edge; after the 8th bit move to PARITY.
REQ-014 SHALL, in PARITY, store the bit and move to STOP.
REQ-015 SHALL, in STOP, return to IDLE on the edge; accept the byte only if stop=1 and the 9 data+parity bits have an odd count of ones.
REQ-016 SHALL set frame_err and discard the byte on a parity or stop failure.
REQ-017 SHALL count clk cycles since the last edge while not in IDLE; on reaching TIMEOUT_CYCLES return to IDLE, discard the partial byte, and set frame_err.
REQ-018 SHALL push an accepted byte into the FIFO on the clk cycle after the stop-bit edge; data[15] and data[7:0] reflect it one cycle later.
REQ-019 SHALL drive data[7:0] with the head byte when nonempty, else 8'h00; data[12:8] always 0.
REQ-020 SHALL, on ren with FIFO nonempty, advance the head on that edge; ren when empty changes no entries.
REQ-021 SHALL clear overflow and frame_err on any ren cycle, unless a new error occurs in that same cycle, in which case the flag remains set.
REQ-022 SHALL, on push and pop in the same cycle, perform both and leave occupancy unchanged, including when full.
REQ-023 SHALL, on push when full without a same-cycle pop, drop the new byte and set overflow; existing entries are unchanged.
REQ-024 SHALL use wrap-around read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty distinction.

Reset
REQ-025 SHALL, while reset_n=0, force state IDLE, FIFO empty, pointers 0, shift register 0, timeout counter 0, synchronizers to 1, and all flags 0, so that data=16'h0000.
REQ-026 SHALL abandon any partial frame on reset assertion mid-frame; the next frame after release is received normally.
REQ-027 SHALL ignore ren and line activity while reset_n=0.

Verification
REQ-028 SHALL pass this scenario: frame for 8'h1C with parity 0 and stop 1 -> data=16'h801C two cycles after the stop edge; ren -> data=16'h0000.
REQ-029 SHALL pass this scenario: frame 8'h1C with parity 1 -> FIFO stays empty, data=16'h2000; ren -> 16'h0000.
REQ-030 SHALL pass this scenario: 9 valid bytes 8'h01..8'h09 with no ren -> data=16'hC001; 8 pops return 01..08, then data=16'h0000.
REQ-031 SHALL pass this scenario: start + 3 bits, then idle TIMEOUT_CYCLES -> data=16'h2000; the following full frame 8'hF0 yields 16'hA0F0.
REQ-032 SHALL pass this scenario: FIFO full (8 entries), ren asserted in the cycle the 9th byte pushes -> overflow stays 0, occupancy 8, last entry is the 9th byte.
REQ-033 SHALL pass this scenario: reset_n pulsed low after 5 bits of a frame -> data=16'h0000; the next frame 8'h5A yields 16'h805A.
